bus_interconnect: RTL
=====================

Name: bus_interconnect

Overview:
- Parametrised single-master, N-slave bus interconnect for the SoC peripheral bus.
- Replaces the hand-wired one-hot CE decode, OR-ed GNT and combinational RDATA mux in the top level.
- Decodes the slave from upper address bits, holds the request stable until the selected slave grants, then registers the read data and returns a one-cycle grant to the core.
- Unmapped accesses return an error response instead of hanging.

Parameters:
- N_SLAVES, 4: number of slave ports (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SEL_MSB, 31: MSB of the slave-select field in the address.
- SEL_LSB, 28: LSB of the slave-select field in the address.
- TIMEOUT_CYCLES, 16: WAIT cycles before abort; used only with BUS_TIMEOUT_EN.

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset, synchronous, active-high.
- i_M_REQ  in  1  master request; held high until o_M_GNT.
- i_M_ADDR  in  ADDR_W  master address.
- i_M_WDATA  in  DATA_W  master write data.
- i_M_WE  in  1  1=write, 0=read.
- i_M_HB  in  2  access size: 00 byte, 01 half, 10 word.
- o_M_GNT  out  1  one-cycle completion pulse.
- o_M_RDATA  out  DATA_W  read data; valid while o_M_GNT=1.
- o_M_ERR  out  1  error flag; valid while o_M_GNT=1.
- o_S_CE  out  N_SLAVES  one-hot slave select.
- o_S_REQ  out  1  slave request.
- o_S_ADDR  out  ADDR_W  latched address (full, not stripped).
- o_S_WDATA  out  DATA_W  latched write data.
- o_S_WE  out  1  latched write enable.
- o_S_HB  out  2  latched access size.
- i_S_GNT  in  N_SLAVES  per-slave grant.
- i_S_RDATA  in  N_SLAVES*DATA_W  per-slave read data; slave k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Clock and reset: single clock i_CLK. Reset i_RST is synchronous, active-high.
- Reset values: every output is 0; state is IDLE; latched fields are 0.
- IDLE:
  - If i_M_REQ=1, compute sel = i_M_ADDR[SEL_MSB:SEL_LSB].
  - If sel < N_SLAVES: latch ADDR/WDATA/WE/HB and sel, go to WAIT.
  - Otherwise go to ERR.
- WAIT:
  - o_S_CE = 1<<sel and o_S_REQ=1, all registered. Latched fields are stable throughout.
  - When i_S_GNT[sel]=1, capture i_S_RDATA slice sel into o_M_RDATA (writes capture it too; software ignores it) and go to RESP.
- RESP:
  - o_M_GNT=1 and o_M_ERR=0 for exactly one cycle.
  - o_S_CE and o_S_REQ are 0.
  - Next state is IDLE.
- ERR:
  - o_M_GNT=1, o_M_ERR=1, o_M_RDATA=0 for one cycle.
  - No slave CE or REQ is ever asserted.
  - Next state is IDLE.
- Latency:
  - Request sampled at cycle 0; WAIT begins in cycle 1.
  - A grant in the first WAIT cycle gives o_M_GNT in cycle 2, so total latency is 2 + slave wait cycles.
  - Unmapped access: o_M_GNT in cycle 1.
- Handshake rules:
  - i_M_REQ is ignored in WAIT, RESP and ERR.
  - A back-to-back request is accepted in the IDLE cycle immediately after RESP or ERR.
- Grant rules:
  - i_S_GNT bits of non-selected slaves are ignored in every state.
  - Any i_S_GNT in IDLE is ignored.
- Mid-transfer changes: changes to master inputs during WAIT have no effect on the slave side.
- Reset mid-operation: on the next cycle all outputs are 0 and the state is IDLE. No o_M_GNT is issued for the aborted access.
- Address decode: sel width = SEL_MSB-SEL_LSB+1. It is compared unsigned against N_SLAVES. Bits outside the field are passed through unchanged.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT and increments each WAIT cycle without a matching grant.
  - After TIMEOUT_CYCLES WAIT cycles, go to ERR: o_M_GNT=1 with o_M_ERR=1 and o_M_RDATA=0. o_S_CE and o_S_REQ drop in that same cycle.
  - A grant arriving in the final WAIT cycle wins over the timeout.
- Undefined: no counter; WAIT lasts indefinitely until the selected slave grants.

Decomposition:
- Shared package bus_pkg:
  - State encoding: IDLE, WAIT, RESP, ERR.
  - HB encodings: HB_BYTE=2'b00, HB_HALF=2'b01, HB_WORD=2'b10.
  - Default slave-map constants: SLV_ROM=0, SLV_RAM=1, SLV_UART=2, SLV_TIMER=3.
- One sub-module, bus_addr_decode: combinational address to {valid, sel, one-hot}, parametrised by N_SLAVES, SEL_MSB and SEL_LSB. The FSM, latches, timeout and RDATA capture stay in bus_interconnect.

Test Plan:
- Read, zero-wait: N_SLAVES=4, read 0x1000_0010; slave 1 grants in cycle 1 with rdata 0xDEADBEEF -> o_S_CE=4'b0010 in cycle 1; o_M_GNT=1, o_M_RDATA=0xDEADBEEF, o_M_ERR=0 in cycle 2; CE=0 in cycle 2.
- Write with wait states: write 0x2000_0004, wdata 0x41, HB=00; slave 2 grants in cycle 4 -> o_S_WE=1, o_S_WDATA=0x41 and o_S_HB=00 stable in cycles 1-4, even though the master changes WDATA in cycle 2; o_M_GNT in cycle 5.
- Unmapped access: read 0x5000_0000 -> o_S_CE=0 throughout; o_M_GNT=1, o_M_ERR=1, o_M_RDATA=0 in cycle 1; back-to-back read 0x0000_0000 is accepted in cycle 2.
- Stray grant: i_S_GNT=4'b1000 in cycles 1-3 while slave 0 is selected -> no o_M_GNT; slave 0 grants in cycle 4 -> o_M_GNT in cycle 5 carrying slave 0's data.
- Timeout, BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=16: slave never grants -> WAIT in cycles 1-16; o_M_GNT=1, o_M_ERR=1 in cycle 17; CE=0 in cycle 17. Without the macro: still in WAIT at cycle 100.
- Reset mid-operation: i_RST=1 during cycle 2 of WAIT -> cycle 3 all outputs 0 and no o_M_GNT issued; a following read of 0x1000_0000 completes normally in 2 cycles.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus interconnect.
// Contents: FSM state encoding, access-size (HB) encodings, default slave map.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  localparam int unsigned SLV_ROM   = 0;
  localparam int unsigned SLV_RAM   = 1;
  localparam int unsigned SLV_UART  = 2;
  localparam int unsigned SLV_TIMER = 3;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational slave decode from the upper address field.
// Ports:
//   i_addr     : full master address
//   o_valid_c  : field selects an existing slave (unsigned compare vs N_SLAVES)
//   o_sel_c    : raw slave-select field
//   o_onehot_c : one-hot slave select, all zero when not valid
module bus_addr_decode #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SEL_MSB  = 31,
  parameter int unsigned SEL_LSB  = 28
) (
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     o_valid_c,
  output logic [SEL_MSB-SEL_LSB:0] o_sel_c,
  output logic [N_SLAVES-1:0]      o_onehot_c
);

  localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;

  // Only the select field matters; the remaining bits travel to the slave untouched.
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr;

  always_comb begin
    o_sel_c    = i_addr[SEL_MSB:SEL_LSB];
    o_valid_c  = (32'(o_sel_c) < 32'(N_SLAVES));
    o_onehot_c = '0;
    if (o_valid_c) begin
      o_onehot_c = N_SLAVES'(1'b1) << o_sel_c;
    end
  end

  // SEL_W kept for readers checking field sizing against N_SLAVES.
  localparam int unsigned UNUSED_SEL_W = SEL_W;

endmodule

// File: rtl/bus_interconnect.sv
// Single-master, N-slave peripheral bus interconnect.
// Decodes the slave from the address, holds a latched request until the selected
// slave grants, registers its read data and returns a one-cycle grant to the core.
// Unmapped accesses complete with o_M_ERR instead of hanging.
// Optional: define BUS_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with an error.
// Ports:
//   i_CLK, i_RST                          : clock, synchronous active-high reset
//   i_M_REQ/ADDR/WDATA/WE/HB              : master request
//   o_M_GNT/RDATA/ERR                     : master completion (registered)
//   o_S_CE/REQ/ADDR/WDATA/WE/HB           : slave-side request (registered)
//   i_S_GNT, i_S_RDATA                    : per-slave grant and read data
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned N_SLAVES       = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SEL_MSB        = 31,
  parameter int unsigned SEL_LSB        = 28,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         i_CLK,
  input  logic                         i_RST,
  input  logic                         i_M_REQ,
  input  logic [ADDR_W-1:0]            i_M_ADDR,
  input  logic [DATA_W-1:0]            i_M_WDATA,
  input  logic                         i_M_WE,
  input  logic [1:0]                   i_M_HB,
  output logic                         o_M_GNT,
  output logic [DATA_W-1:0]            o_M_RDATA,
  output logic                         o_M_ERR,
  output logic [N_SLAVES-1:0]          o_S_CE,
  output logic                         o_S_REQ,
  output logic [ADDR_W-1:0]            o_S_ADDR,
  output logic [DATA_W-1:0]            o_S_WDATA,
  output logic                         o_S_WE,
  output logic [1:0]                   o_S_HB,
  input  logic [N_SLAVES-1:0]          i_S_GNT,
  input  logic [N_SLAVES*DATA_W-1:0]   i_S_RDATA
);

  localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;

  logic                w_dec_valid;
  logic [SEL_W-1:0]    w_dec_sel;
  logic [N_SLAVES-1:0] w_dec_onehot;

  state_t              r_state, w_state_next;
  logic [SEL_W-1:0]    r_sel;
  logic [N_SLAVES-1:0] r_s_ce, w_s_ce_next;
  logic                r_s_req, w_s_req_next;
  logic                r_m_gnt, w_m_gnt_next;
  logic                r_m_err, w_m_err_next;
  logic [DATA_W-1:0]   r_m_rdata, w_m_rdata_next;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [DATA_W-1:0]   r_s_wdata;
  logic                r_s_we;
  logic [1:0]          r_s_hb;
  logic                w_latch;
  logic                w_gnt_hit;
  logic [DATA_W-1:0]   w_sel_rdata;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  bus_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .SEL_MSB  (SEL_MSB),
    .SEL_LSB  (SEL_LSB)
  ) u_decode (
    .i_addr     (i_M_ADDR),
    .o_valid_c  (w_dec_valid),
    .o_sel_c    (w_dec_sel),
    .o_onehot_c (w_dec_onehot)
  );

  // Grant and read data of the latched slave only; other slaves' grants are ignored.
  always_comb begin
    w_gnt_hit   = 1'b0;
    w_sel_rdata = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_gnt_hit   = i_S_GNT[k];
        w_sel_rdata = i_S_RDATA[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    w_state_next   = r_state;
    w_s_ce_next    = '0;
    w_s_req_next   = 1'b0;
    w_m_gnt_next   = 1'b0;
    w_m_err_next   = 1'b0;
    w_m_rdata_next = '0;
    w_latch        = 1'b0;
`ifdef BUS_TIMEOUT_EN
    w_cnt_next     = r_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (i_M_REQ) begin
          if (w_dec_valid) begin
            w_state_next = WAIT;
            w_latch      = 1'b1;
            w_s_ce_next  = w_dec_onehot;
            w_s_req_next = 1'b1;
`ifdef BUS_TIMEOUT_EN
            w_cnt_next   = '0;
`endif
          end else begin
            w_state_next = ERR;
            w_m_gnt_next = 1'b1;
            w_m_err_next = 1'b1;
          end
        end
      end
      WAIT: begin
        // A grant in the last WAIT cycle takes priority over the timeout.
        if (w_gnt_hit) begin
          w_state_next   = RESP;
          w_m_gnt_next   = 1'b1;
          w_m_rdata_next = w_sel_rdata;
        end else begin
          w_s_ce_next  = r_s_ce;
          w_s_req_next = 1'b1;
`ifdef BUS_TIMEOUT_EN
          if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_next = ERR;
            w_s_ce_next  = '0;
            w_s_req_next = 1'b0;
            w_m_gnt_next = 1'b1;
            w_m_err_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
`endif
        end
      end
      RESP:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, output and request-latch registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_s_ce    <= '0;
      r_s_req   <= 1'b0;
      r_m_gnt   <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_rdata <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_we    <= 1'b0;
      r_s_hb    <= 2'b00;
`ifdef BUS_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_s_ce    <= w_s_ce_next;
      r_s_req   <= w_s_req_next;
      r_m_gnt   <= w_m_gnt_next;
      r_m_err   <= w_m_err_next;
      r_m_rdata <= w_m_rdata_next;
`ifdef BUS_TIMEOUT_EN
      r_cnt     <= w_cnt_next;
`endif
      if (w_latch) begin
        r_sel     <= w_dec_sel;
        r_s_addr  <= i_M_ADDR;
        r_s_wdata <= i_M_WDATA;
        r_s_we    <= i_M_WE;
        r_s_hb    <= i_M_HB;
      end
    end
  end

  assign o_M_GNT   = r_m_gnt;
  assign o_M_RDATA = r_m_rdata;
  assign o_M_ERR   = r_m_err;
  assign o_S_CE    = r_s_ce;
  assign o_S_REQ   = r_s_req;
  assign o_S_ADDR  = r_s_addr;
  assign o_S_WDATA = r_s_wdata;
  assign o_S_WE    = r_s_we;
  assign o_S_HB    = r_s_hb;

endmodule
